sdram_responder: RTL and testbench

//  Synthesizable SDR SDRAM device responder: the target end of the sdram controller's pin interface.

---
 rtl/sdram_pkg.sv | 59 +++++
 rtl/sdram_resp_mem.sv | 39 +++
 rtl/sdram_responder.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared command encodings, error codes and mode-register decode for the SDRAM responder.
package sdram_pkg;

  // {RAS,CAS,WE} command encodings (active-low strobes, CS asserted)
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_t;

  // Burst engine state
  typedef enum logic [1:0] {
    BURST_IDLE  = 2'd0,
    BURST_READ  = 2'd1,
    BURST_WRITE = 2'd2
  } burst_t;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_IDLE_BANK  = 3'd1;
  localparam logic [2:0] ERR_ACT_ACTIVE = 3'd2;
  localparam logic [2:0] ERR_REF_BUSY   = 3'd3;
  localparam logic [2:0] ERR_MRS_BUSY   = 3'd4;
  localparam logic [2:0] ERR_NO_MODE    = 3'd5;
  localparam logic [2:0] ERR_BAD_MODE   = 3'd6;

  // Decoded mode register: burst length minus one, CAS latency 3 flag, legality
  typedef struct packed {
    logic       ok;
    logic [2:0] bl_m1;
    logic       cl3;
  } mode_t;

  // Decode BL from A[2:0] and CL from A[6:4]; anything outside BL 1/2/4/8, CL 2/3 is illegal
  function automatic mode_t decode_mode(input logic [12:0] a);
    mode_t m;
    m.ok    = 1'b1;
    m.bl_m1 = 3'd0;
    m.cl3   = 1'b0;
    case (a[2:0])
      3'd0:    m.bl_m1 = 3'd0;
      3'd1:    m.bl_m1 = 3'd1;
      3'd2:    m.bl_m1 = 3'd3;
      3'd3:    m.bl_m1 = 3'd7;
      default: m.ok    = 1'b0;
    endcase
    case (a[6:4])
      3'd2:    m.cl3 = 1'b0;
      3'd3:    m.cl3 = 1'b1;
      default: m.ok  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store for the responder: one byte-enabled write port, one registered read port.
// Contents are intentionally not reset so data survives a responder reset.
module sdram_resp_mem
  import sdram_pkg::*;
#(
  parameter int AW   = 10,
  parameter int DQ_W = 16
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [DQ_W-1:0]     i_wr_data,
  input  logic [DQ_W/8-1:0]   i_wr_be,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [DQ_W-1:0]     o_rd_data
);

  localparam int LANES = DQ_W / 8;

  logic [DQ_W-1:0] r_mem [2**AW];
  logic [DQ_W-1:0] r_rd_data;

  // Byte-lane write port
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i_we && i_wr_be[i]) begin
        r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
      end
    end
  end

  // Registered read port (one cycle of latency)
  always_ff @(posedge i_clk) begin
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device model: decodes controller commands, tracks banks and mode,
// serves CL-delayed read bursts and byte-masked write bursts, latches the first protocol violation.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int DQ_W     = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_sdramCs,
  input  logic                i_sdramRas,
  input  logic                i_sdramCas,
  input  logic                i_sdramWe,
  input  logic [DQ_W/8-1:0]   i_sdramDqm,
  input  logic [1:0]          i_sdramBa,
  input  logic [12:0]         i_sdramA,
  input  logic [DQ_W-1:0]     i_sdramDqIn,
  output logic [DQ_W-1:0]     o_sdramDqOut,
  output logic                o_sdramDqOe,
  output logic                o_protoError,
  output logic [2:0]          o_errorCode
);

  localparam int LANES = DQ_W / 8;
  localparam int AW    = 2 + ROW_BITS + COL_BITS;

  // Bank table and mode register
  logic [3:0]          r_bank_open;
  logic [ROW_BITS-1:0] r_bank_row [4];
  logic                r_mode_ok;
  logic [2:0]          r_bl_m1;
  logic                r_cl3;

  // Burst engine
  burst_t              r_burst;
  logic [1:0]          r_b_bank;
  logic [ROW_BITS-1:0] r_b_row;
  logic [COL_BITS-1:0] r_b_col;
  logic [2:0]          r_b_cnt;
  logic                r_b_ap;

  // CAS-latency pipe and read DQM delay
  logic                r_v0, r_v1, r_v2;
  logic [DQ_W-1:0]     r_d1, r_d2;
  logic [LANES-1:0]    r_dqm1, r_dqm2;
  logic [DQ_W-1:0]     r_dq_out;
  logic                r_dq_oe;

  // Sticky error
  logic                r_err;
  logic [2:0]          r_err_code;

  // Decode signals
  cmd_t                w_cmd;
  mode_t               w_mode;
  logic                w_all_idle, w_sel_open;
  logic                w_err;
  logic [2:0]          w_err_code;
  logic                w_do_mrs, w_do_act, w_do_rw, w_do_pre, w_do_bst;
  logic                w_pre_hit, w_cont, w_last, w_wr_start;
  logic                w_issue_rd, w_issue_wr;
  logic [1:0]          w_bank;
  logic [ROW_BITS-1:0] w_row;
  logic [COL_BITS-1:0] w_start, w_mask, w_col;
  logic [2:0]          w_k;
  logic [AW-1:0]       w_addr;
  logic [DQ_W-1:0]     w_rd_data;
  logic                w_tap_v;
  logic [DQ_W-1:0]     w_tap_d, w_tap_masked;
  logic                w_unused;

  assign w_unused   = &{1'b0, i_sdramA};
  assign w_cmd      = i_sdramCs ? CMD_NOP : cmd_t'({i_sdramRas, i_sdramCas, i_sdramWe});
  assign w_mode     = decode_mode(i_sdramA);
  assign w_all_idle = (r_bank_open == 4'b0000);
  assign w_sel_open = r_bank_open[i_sdramBa];

  // Command legality check and action strobes
  always_comb begin
    w_err      = 1'b0;
    w_err_code = ERR_NONE;
    w_do_mrs   = 1'b0;
    w_do_act   = 1'b0;
    w_do_rw    = 1'b0;
    w_do_pre   = 1'b0;
    w_do_bst   = 1'b0;
    case (w_cmd)
      CMD_NOP: w_err = 1'b0;
      CMD_MRS: begin
        if (!w_all_idle) begin
          w_err      = 1'b1;
          w_err_code = ERR_MRS_BUSY;
        end else if (!w_mode.ok) begin
          w_err      = 1'b1;
          w_err_code = ERR_BAD_MODE;
        end else begin
          w_do_mrs   = 1'b1;
        end
      end
      default: begin
        if (!r_mode_ok) begin
          w_err      = 1'b1;
          w_err_code = ERR_NO_MODE;
        end else begin
          case (w_cmd)
            CMD_ACT: begin
              if (w_sel_open) begin
                w_err      = 1'b1;
                w_err_code = ERR_ACT_ACTIVE;
              end else begin
                w_do_act   = 1'b1;
              end
            end
            CMD_RD, CMD_WR: begin
              if (!w_sel_open) begin
                w_err      = 1'b1;
                w_err_code = ERR_IDLE_BANK;
              end else begin
                w_do_rw    = 1'b1;
              end
            end
            CMD_PRE: w_do_pre = 1'b1;
            CMD_REF: begin
              if (!w_all_idle) begin
                w_err      = 1'b1;
                w_err_code = ERR_REF_BUSY;
              end else begin
                w_err      = 1'b0;
              end
            end
            CMD_BST: w_do_bst = 1'b1;
            default: w_err = 1'b0;
          endcase
        end
      end
    endcase
  end

  // A new RD/WR restarts the burst; BST or a PRE covering the burst bank kills it
  assign w_pre_hit  = w_do_pre && (r_burst != BURST_IDLE) && (i_sdramA[10] || (i_sdramBa == r_b_bank));
  assign w_cont     = (r_burst != BURST_IDLE) && !w_do_rw && !w_do_bst && !w_pre_hit;
  assign w_last     = w_cont && (r_b_cnt == r_bl_m1);
  assign w_wr_start = w_do_rw && (w_cmd == CMD_WR);
  assign w_issue_rd = (w_do_rw && (w_cmd == CMD_RD)) || (w_cont && (r_burst == BURST_READ));
  assign w_issue_wr = w_wr_start || (w_cont && (r_burst == BURST_WRITE));

  // Beat address: sequential wrap inside the BL-aligned column block
  assign w_bank  = w_do_rw ? i_sdramBa : r_b_bank;
  assign w_row   = w_do_rw ? r_bank_row[i_sdramBa] : r_b_row;
  assign w_start = w_do_rw ? i_sdramA[COL_BITS-1:0] : r_b_col;
  assign w_k     = w_do_rw ? 3'd0 : r_b_cnt;
  assign w_mask  = COL_BITS'(r_bl_m1);
  assign w_col   = (w_start & ~w_mask) | ((w_start + COL_BITS'(w_k)) & w_mask);
  assign w_addr  = {w_bank, w_row, w_col};

  sdram_resp_mem #(
    .AW   (AW),
    .DQ_W (DQ_W)
  ) u_mem (
    .i_clk     (i_clock),
    .i_we      (w_issue_wr),
    .i_wr_addr (w_addr),
    .i_wr_data (i_sdramDqIn),
    .i_wr_be   (~i_sdramDqm),
    .i_rd_addr (w_addr),
    .o_rd_data (w_rd_data)
  );

  // Select the pipe stage matching CAS latency and apply delayed read DQM per lane
  always_comb begin
    w_tap_v      = r_cl3 ? r_v2 : r_v1;
    w_tap_d      = r_cl3 ? r_d2 : r_d1;
    w_tap_masked = w_tap_d;
    for (int i = 0; i < LANES; i++) begin
      w_tap_masked[8*i +: 8] = r_dqm2[i] ? 8'h00 : w_tap_d[8*i +: 8];
    end
  end

  // Mode register and per-bank open/row tracking
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bank_open <= 4'b0000;
      r_mode_ok   <= 1'b0;
      r_bl_m1     <= 3'd0;
      r_cl3       <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        r_bank_row[b] <= '0;
      end
    end else begin
      if (w_do_mrs) begin
        r_mode_ok <= 1'b1;
        r_bl_m1   <= w_mode.bl_m1;
        r_cl3     <= w_mode.cl3;
      end
      if (w_last && r_b_ap) begin
        r_bank_open[r_b_bank] <= 1'b0;
      end
      if (w_do_rw && i_sdramA[10] && (r_bl_m1 == 3'd0)) begin
        r_bank_open[i_sdramBa] <= 1'b0;
      end
      if (w_do_act) begin
        r_bank_open[i_sdramBa] <= 1'b1;
        r_bank_row[i_sdramBa]  <= i_sdramA[ROW_BITS-1:0];
      end
      if (w_do_pre) begin
        if (i_sdramA[10]) begin
          r_bank_open <= 4'b0000;
        end else begin
          r_bank_open[i_sdramBa] <= 1'b0;
        end
      end
    end
  end

  // Burst engine: beat 0 issues in the command cycle, the rest on following cycles
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_burst  <= BURST_IDLE;
      r_b_bank <= 2'd0;
      r_b_row  <= '0;
      r_b_col  <= '0;
      r_b_cnt  <= 3'd0;
      r_b_ap   <= 1'b0;
    end else if (w_do_rw) begin
      r_b_bank <= i_sdramBa;
      r_b_row  <= r_bank_row[i_sdramBa];
      r_b_col  <= i_sdramA[COL_BITS-1:0];
      r_b_cnt  <= 3'd1;
      r_b_ap   <= i_sdramA[10];
      if (r_bl_m1 == 3'd0) begin
        r_burst <= BURST_IDLE;
      end else begin
        r_burst <= (w_cmd == CMD_RD) ? BURST_READ : BURST_WRITE;
      end
    end else if (w_cont) begin
      r_b_cnt <= r_b_cnt + 3'd1;
      if (w_last) begin
        r_burst <= BURST_IDLE;
      end
    end else if (w_do_bst || w_pre_hit) begin
      r_burst <= BURST_IDLE;
    end
  end

  // CAS-latency pipe and registered DQ outputs; a write start silences the bus at once
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_dqm1   <= '0;
      r_dqm2   <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
    end else begin
      r_v0   <= w_issue_rd;
      r_v1   <= r_v0 && !w_wr_start;
      r_v2   <= r_v1 && !w_wr_start;
      r_d1   <= w_rd_data;
      r_d2   <= r_d1;
      r_dqm1 <= i_sdramDqm;
      r_dqm2 <= r_dqm1;
      if (w_wr_start) begin
        r_dq_oe  <= 1'b0;
        r_dq_out <= '0;
      end else if (w_tap_v && !(&r_dqm2)) begin
        r_dq_oe  <= 1'b1;
        r_dq_out <= w_tap_masked;
      end else begin
        r_dq_oe  <= 1'b0;
        r_dq_out <= '0;
      end
    end
  end

  // First protocol violation is latched and held until reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_err && !r_err) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_code;
    end
  end

  assign o_sdramDqOut = r_dq_out;
  assign o_sdramDqOe  = r_dq_oe;
  assign o_protoError = r_err;
  assign o_errorCode  = r_err_code;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: bursts, CL timing, wrap, DQM, BST, errors, reset.
module tb_sdram_responder;

  localparam logic [2:0] K_MRS = 3'b000;
  localparam logic [2:0] K_REF = 3'b001;
  localparam logic [2:0] K_PRE = 3'b010;
  localparam logic [2:0] K_ACT = 3'b011;
  localparam logic [2:0] K_WR  = 3'b100;
  localparam logic [2:0] K_RD  = 3'b101;
  localparam logic [2:0] K_BST = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  dqm = 2'b00;
  logic [1:0]  ba = 2'b00;
  logic [12:0] a = 13'h0000;
  logic [15:0] dqin = 16'h0000;
  logic [15:0] dqout;
  logic        dqoe;
  logic        perr;
  logic [2:0]  ecode;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_responder #(.ROW_BITS(4), .COL_BITS(4), .DQ_W(16)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_sdramCs    (cs),
    .i_sdramRas   (ras),
    .i_sdramCas   (cas),
    .i_sdramWe    (we),
    .i_sdramDqm   (dqm),
    .i_sdramBa    (ba),
    .i_sdramA     (a),
    .i_sdramDqIn  (dqin),
    .o_sdramDqOut (dqout),
    .o_sdramDqOe  (dqoe),
    .o_protoError (perr),
    .o_errorCode  (ecode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge, then return the bus to NOP
  task automatic issue(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d, input logic [1:0] m);
    cs = 1'b0; {ras, cas, we} = rcw; ba = b; a = addr; dqin = d; dqm = m;
    tick();
    cs = 1'b1; {ras, cas, we} = 3'b111; dqm = 2'b00;
  endtask

  task automatic nop_data(input logic [15:0] d, input logic [1:0] m);
    cs = 1'b1; dqin = d; dqm = m;
    tick();
    dqm = 2'b00;
  endtask

  task automatic do_reset();
    cs = 1'b1; rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", dqoe); end
    n_checks++; if (dqout !== 16'h0000) begin n_fail++; $display("FAIL reset_dq: got %h want 0000", dqout); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr); end
    n_checks++; if (ecode !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", ecode); end
  endtask

  // CL2 BL8 write then read of row 3 cols 0..7
  task automatic test_cl2_bl8();
    issue(K_MRS, 2'd0, 13'h023, 16'h0, 2'b00);
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    issue(K_WR, 2'd0, 13'h000, 16'h1000, 2'b00);
    for (int i = 1; i < 8; i++) nop_data(16'h1000 + 16'(i), 2'b00);
    tick();
    issue(K_RD, 2'd0, 13'h000, 16'h0, 2'b00);
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL cl2_early: oe %b want 0 one cycle after RD", dqoe); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (dqoe !== 1'b1 || dqout !== 16'h1000 + 16'(i)) begin
        n_fail++; $display("FAIL cl2_beat%0d: oe=%b dq=%h want oe=1 dq=%h", i, dqoe, dqout, 16'h1000 + 16'(i));
      end
    end
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL cl2_end: oe %b want 0", dqoe); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL cl2_noerr: perr %b code %0d want 0", perr, ecode); end
  endtask

  // CL3 BL4 read starting at col 6 wraps 6,7,4,5
  task automatic test_cl3_wrap();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h1006; exp_d[1] = 16'h1007; exp_d[2] = 16'h1004; exp_d[3] = 16'h1005;
    issue(K_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
    issue(K_MRS, 2'd0, 13'h032, 16'h0, 2'b00);
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    issue(K_RD, 2'd0, 13'h006, 16'h0, 2'b00);
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL cl3_early: oe %b want 0 two cycles after RD", dqoe); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (dqoe !== 1'b1 || dqout !== exp_d[i]) begin
        n_fail++; $display("FAIL cl3_beat%0d: oe=%b dq=%h want oe=1 dq=%h", i, dqoe, dqout, exp_d[i]);
      end
    end
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL cl3_end: oe %b want 0", dqoe); end
  endtask

  // Write byte masks and read DQM latency 2, using CL2 BL1
  task automatic test_dqm();
    issue(K_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
    issue(K_MRS, 2'd0, 13'h020, 16'h0, 2'b00);
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    issue(K_WR, 2'd0, 13'h008, 16'h0000, 2'b00);
    issue(K_WR, 2'd0, 13'h008, 16'hABCD, 2'b01);
    issue(K_WR, 2'd0, 13'h009, 16'h1234, 2'b00);
    issue(K_RD, 2'd0, 13'h008, 16'h0, 2'b00);
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'hAB00) begin n_fail++; $display("FAIL wr_mask: oe=%b dq=%h want oe=1 dq=ab00", dqoe, dqout); end
    issue(K_RD, 2'd0, 13'h008, 16'h0, 2'b11);
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b0 || dqout !== 16'h0000) begin n_fail++; $display("FAIL rd_mask_all: oe=%b dq=%h want oe=0 dq=0000", dqoe, dqout); end
    issue(K_RD, 2'd0, 13'h009, 16'h0, 2'b10);
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h0034) begin n_fail++; $display("FAIL rd_mask_hi: oe=%b dq=%h want oe=1 dq=0034", dqoe, dqout); end
  endtask

  // BL8 read stopped by BST after three beats issued
  task automatic test_bst();
    issue(K_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
    issue(K_MRS, 2'd0, 13'h023, 16'h0, 2'b00);
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    issue(K_RD, 2'd0, 13'h000, 16'h0, 2'b00);
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h1000) begin n_fail++; $display("FAIL bst_beat0: oe=%b dq=%h want oe=1 dq=1000", dqoe, dqout); end
    issue(K_BST, 2'd0, 13'h000, 16'h0, 2'b00);
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h1001) begin n_fail++; $display("FAIL bst_beat1: oe=%b dq=%h want oe=1 dq=1001", dqoe, dqout); end
    tick();
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h1002) begin n_fail++; $display("FAIL bst_beat2: oe=%b dq=%h want oe=1 dq=1002", dqoe, dqout); end
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL bst_stop: oe %b want 0", dqoe); end
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL bst_stop2: oe %b want 0", dqoe); end
  endtask

  // Error latching, stickiness and each error code
  task automatic test_errors();
    issue(K_RD, 2'd1, 13'h000, 16'h0, 2'b00);
    n_checks++; if (perr !== 1'b1 || ecode !== 3'd1) begin n_fail++; $display("FAIL err_idle_rd: perr=%b code=%0d want 1/1", perr, ecode); end
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    n_checks++; if (perr !== 1'b1 || ecode !== 3'd1) begin n_fail++; $display("FAIL err_sticky: perr=%b code=%0d want 1/1", perr, ecode); end
    do_reset();
    n_checks++; if (perr !== 1'b0 || ecode !== 3'd0) begin n_fail++; $display("FAIL err_clear: perr=%b code=%0d want 0/0", perr, ecode); end
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    n_checks++; if (perr !== 1'b1 || ecode !== 3'd5) begin n_fail++; $display("FAIL err_no_mode: perr=%b code=%0d want 1/5", perr, ecode); end
    do_reset();
    issue(K_MRS, 2'd0, 13'h027, 16'h0, 2'b00);
    n_checks++; if (perr !== 1'b1 || ecode !== 3'd6) begin n_fail++; $display("FAIL err_bad_mode: perr=%b code=%0d want 1/6", perr, ecode); end
    do_reset();
    issue(K_MRS, 2'd0, 13'h023, 16'h0, 2'b00);
    issue(K_ACT, 2'd2, 13'h000, 16'h0, 2'b00);
    issue(K_REF, 2'd0, 13'h000, 16'h0, 2'b00);
    n_checks++; if (perr !== 1'b1 || ecode !== 3'd3) begin n_fail++; $display("FAIL err_ref_busy: perr=%b code=%0d want 1/3", perr, ecode); end
    do_reset();
    issue(K_MRS, 2'd0, 13'h023, 16'h0, 2'b00);
    issue(K_ACT, 2'd2, 13'h000, 16'h0, 2'b00);
    issue(K_MRS, 2'd0, 13'h023, 16'h0, 2'b00);
    n_checks++; if (perr !== 1'b1 || ecode !== 3'd4) begin n_fail++; $display("FAIL err_mrs_busy: perr=%b code=%0d want 1/4", perr, ecode); end
    do_reset();
  endtask

  // Auto-precharge read (BL2) then re-ACT the same bank; memory survived the resets
  task automatic test_autopre();
    issue(K_MRS, 2'd0, 13'h021, 16'h0, 2'b00);
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    issue(K_RD, 2'd0, 13'h402, 16'h0, 2'b00);
    tick();
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h1002) begin n_fail++; $display("FAIL ap_beat0: oe=%b dq=%h want oe=1 dq=1002", dqoe, dqout); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL ap_reopen: perr=%b code=%0d want 0", perr, ecode); end
    tick();
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h1003) begin n_fail++; $display("FAIL ap_beat1: oe=%b dq=%h want oe=1 dq=1003", dqoe, dqout); end
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL ap_end: oe %b want 0", dqoe); end
  endtask

  // Reset in the middle of a BL8 read flushes burst and pipe
  task automatic test_reset_mid_burst();
    do_reset();
    issue(K_MRS, 2'd0, 13'h023, 16'h0, 2'b00);
    issue(K_ACT, 2'd0, 13'h003, 16'h0, 2'b00);
    issue(K_RD, 2'd0, 13'h000, 16'h0, 2'b00);
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b1 || dqout !== 16'h1000) begin n_fail++; $display("FAIL mid_beat0: oe=%b dq=%h want oe=1 dq=1000", dqoe, dqout); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL mid_flush: oe %b want 0", dqoe); end
    tick();
    tick();
    n_checks++; if (dqoe !== 1'b0) begin n_fail++; $display("FAIL mid_flush2: oe %b want 0", dqoe); end
  endtask

  initial begin
    test_reset();
    test_cl2_bl8();
    test_cl3_wrap();
    test_dqm();
    test_bst();
    test_errors();
    test_autopre();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
